sync_fifo_flags: RTL

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

---
 rtl/sync_fifo_flags_if.sv | 38 +++
 rtl/sync_fifo_flags.sv | 112 +++++++++++
 2 files changed

// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if -- handshake bundle for the flagged synchronous FIFO.
//
// Signals:
//   wr_en, wr_data        write request and write word     (master -> slave)
//   rd_en                 read request                     (master -> slave)
//   rd_data               read word                        (slave -> master)
//   wr_full, rd_empty     occupancy == DEPTH / == 0        (slave -> master)
//   almost_full/_empty    threshold flags                  (slave -> master)
//   fill_count            occupancy 0..DEPTH               (slave -> master)
//   overflow, underflow   one-cycle error pulses           (slave -> master)
interface sync_fifo_flags_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 16
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_full;
    logic                  rd_empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   fill_count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, wr_full, rd_empty, almost_full, almost_empty,
               fill_count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, wr_full, rd_empty, almost_full, almost_empty,
               fill_count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags -- single-clock FIFO with registered status flags.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset (clears pointers, count, flags, rd_data)
//   bus    sync_fifo_flags_if.slave: write/read handshake, read data,
//          full/empty/almost flags, fill_count, overflow/underflow pulses
//
// FWFT=0: rd_data is registered and updates the cycle after an accepted read.
// FWFT=1: rd_data shows the head entry whenever the FIFO is not empty.
module sync_fifo_flags #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 16,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 1,
    parameter int AE_THRESH  = 1,
    parameter bit FWFT       = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    sync_fifo_flags_if.slave bus
);
    localparam int              DEPTH   = 1 << ADDR_WIDTH;
    localparam int              CW      = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0]   AE_C    = CW'(AE_THRESH);
    localparam logic            AF_RST  = (AF_THRESH == 0);

    generate
        if (AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_thresh
            $error("sync_fifo_flags: AF_THRESH must be 1..DEPTH and AE_THRESH 0..DEPTH-1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  full_q;
    logic                  empty_q;
    logic                  af_q;
    logic                  ae_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic                  wr_acc;
    logic                  rd_acc;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = bus.rd_en && !empty_q;
    assign wr_acc = bus.wr_en && (!full_q || rd_acc);

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Flags are computed from the next count so they line up with fill_count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= AF_RST;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            count   <= count_nxt;
            full_q  <= (count_nxt == DEPTH_C);
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= AF_C);
            ae_q    <= (count_nxt <= AE_C);
            ovf_q   <= bus.wr_en && full_q && !rd_acc;
            udf_q   <= bus.rd_en && empty_q;
        end
    end

    // Storage is not reset; contents are meaningless once pointers are cleared.
    always_ff @(posedge clk) begin
        if (reset && wr_acc) mem[wr_ptr] <= bus.wr_data;
    end

    generate
        if (FWFT) begin : g_fwft
            assign bus.rd_data = empty_q ? '0 : mem[rd_ptr];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rd_q;
            always_ff @(posedge clk) begin
                if (!reset)      rd_q <= '0;
                else if (rd_acc) rd_q <= mem[rd_ptr];
            end
            assign bus.rd_data = rd_q;
        end
    endgenerate

    assign bus.wr_full      = full_q;
    assign bus.rd_empty     = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.fill_count   = count;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule
